// File: rtl/led_anim_pkg.sv
// ----------------------------------------------------------------------------
// led_anim_pkg: shared defaults and period helper for the LED animation tick generator.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package led_anim_pkg;

    localparam int DEF_NUM_LEVELS    = 12;
    localparam int DEF_BASE_LOG2     = 2;
    localparam int DEF_DEFAULT_LEVEL = 6;
    localparam int DEF_HOLD_CYCLES   = 1 << 24;
    localparam int DEF_REPEAT_CYCLES = 1 << 22;

    // Callers truncate the result to their counter width.
    function automatic logic [63:0] period_m1(input int base_log2, input int lvl);
        return (64'd1 << (base_log2 + lvl)) - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rate_tick_gen_if.sv
// ----------------------------------------------------------------------------
// rate_tick_gen_if: button/enable inputs and tick/level outputs of the tick generator.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rate_tick_gen_if #(
    parameter int LEVEL_W = $clog2(led_anim_pkg::DEF_NUM_LEVELS)
);
    logic               up;
    logic               down;
    logic               en;
    logic               tick;
    logic [LEVEL_W-1:0] level;
    logic               at_min;
    logic               at_max;

    modport master (output up, down, en, input tick, level, at_min, at_max);
    modport slave  (input up, down, en, output tick, level, at_min, at_max);
endinterface

`default_nettype wire

// File: rtl/step_button.sv
// ----------------------------------------------------------------------------
// step_button: synchronizer, press detect and hold-to-repeat step generator.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module step_button #(
    parameter int HOLD_CYCLES   = led_anim_pkg::DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = led_anim_pkg::DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic other_held,
    output logic step,
    output logic held
);
    import led_anim_pkg::*;

    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW      = $clog2(MAX_CYC) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          prev;
    logic          repeating;
    logic [HW-1:0] hold_cnt;
    logic          press;
    logic          alone;
    logic          expire;

    assign press  = sync & ~prev;
    assign alone  = sync & ~other_held;
    // Expiry is only meaningful after the press cycle, hence the prev term.
    assign expire = alone & prev & (hold_cnt == (repeating ? REP_LAST : HOLD_LAST));
    assign step   = press | expire;
    assign held   = sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            prev      <= 1'b0;
            repeating <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
            if (press || !alone) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (expire) begin
                hold_cnt  <= '0;
                repeating <= 1'b1;
            end else begin
                hold_cnt  <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rate_tick_gen.sv
// ----------------------------------------------------------------------------
// rate_tick_gen: power-of-two period tick generator with up/down rate buttons.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rate_tick_gen #(
    parameter int NUM_LEVELS    = led_anim_pkg::DEF_NUM_LEVELS,
    parameter int BASE_LOG2     = led_anim_pkg::DEF_BASE_LOG2,
    parameter int DEFAULT_LEVEL = led_anim_pkg::DEF_DEFAULT_LEVEL,
    parameter int HOLD_CYCLES   = led_anim_pkg::DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = led_anim_pkg::DEF_REPEAT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    rate_tick_gen_if.slave bus
);
    import led_anim_pkg::*;

    localparam int LEVEL_W = $clog2(NUM_LEVELS);
    localparam int CNT_W   = BASE_LOG2 + NUM_LEVELS - 1;
    localparam logic [LEVEL_W-1:0] MAX_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] RESET_LEVEL = LEVEL_W'(DEFAULT_LEVEL);

    function automatic logic [CNT_W-1:0] reload_for(input logic [LEVEL_W-1:0] lvl);
        return CNT_W'(period_m1(BASE_LOG2, int'(lvl)));
    endfunction

    logic               up_step;
    logic               down_step;
    logic               up_held;
    logic               down_held;
    logic               go_faster;
    logic               go_slower;
    logic               change;
    logic [LEVEL_W-1:0] next_level;
    logic [LEVEL_W-1:0] level_q;
    logic [CNT_W-1:0]   cnt;
    logic               tick_q;

    step_button #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
        .clk        (clk),
        .reset      (reset),
        .btn        (bus.up),
        .other_held (down_held),
        .step       (up_step),
        .held       (up_held)
    );

    step_button #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
        .clk        (clk),
        .reset      (reset),
        .btn        (bus.down),
        .other_held (up_held),
        .step       (down_step),
        .held       (down_held)
    );

    // Coincident requests cancel; saturated requests are dropped entirely.
    always_comb begin
        go_faster  = up_step & ~down_step & (level_q != '0);
        go_slower  = down_step & ~up_step & (level_q != MAX_LEVEL);
        next_level = level_q;
        if (go_faster) begin
            next_level = level_q - LEVEL_W'(1);
        end else if (go_slower) begin
            next_level = level_q + LEVEL_W'(1);
        end
    end

    assign change = go_faster | go_slower;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= RESET_LEVEL;
            cnt     <= reload_for(RESET_LEVEL);
            tick_q  <= 1'b0;
        end else if (change) begin
            level_q <= next_level;
            cnt     <= reload_for(next_level);
            tick_q  <= 1'b0;
        end else if (bus.en) begin
            if (cnt == '0) begin
                cnt    <= reload_for(level_q);
                tick_q <= 1'b1;
            end else begin
                cnt    <= cnt - CNT_W'(1);
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign bus.tick   = tick_q;
    assign bus.level  = level_q;
    assign bus.at_min = (level_q == '0);
    assign bus.at_max = (level_q == MAX_LEVEL);

endmodule

`default_nettype wire

// File: tb/tb_rate_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_rate_tick_gen: scoreboard bench with a cycle-level reference model of rate_tick_gen.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rate_tick_gen;
    localparam int NL = 4;
    localparam int BL = 2;
    localparam int DL = 1;
    localparam int HC = 16;
    localparam int RC = 8;
    localparam int LW = 2;

    typedef struct {
        int edge_no;
        bit tick;
        int level;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rate_tick_gen_if #(.LEVEL_W(LW)) bus ();

    rate_tick_gen #(
        .NUM_LEVELS    (NL),
        .BASE_LOG2     (BL),
        .DEFAULT_LEVEL (DL),
        .HOLD_CYCLES   (HC),
        .REPEAT_CYCLES (RC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input int edge_no, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_no, act, req);
        end
    endtask

    function automatic int period(input int k);
        return 1 << (BL + k);
    endfunction

    // A held-alone button repeats HC edges after its last restart, then every RC.
    function automatic bit repeat_due(input int n);
        return (n >= HC) && (((n - HC) % RC) == 0);
    endfunction

    // Reference model: one expectation per rising edge.
    int m_edge, m_lvl, m_due, anc_u, anc_d;
    bit hu[$] = '{0, 0, 0, 0};
    bit hd[$] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        exp_t r;
        bit   su, sup, sd, sdp, stu, std, changed;
        r.tick  = 1'b0;
        changed = 1'b0;
        if (!reset) begin
            m_edge = 0;
            m_lvl  = DL;
            m_due  = period(DL);
            anc_u  = 0;
            anc_d  = 0;
            hu     = '{0, 0, 0, 0};
            hd     = '{0, 0, 0, 0};
        end else begin
            m_edge++;
            hu.push_back(bus.up);
            void'(hu.pop_front());
            hd.push_back(bus.down);
            void'(hd.pop_front());
            // Two-flop synchronizer: level seen at this edge was raw two edges earlier.
            su = hu[1]; sup = hu[0]; sd = hd[1]; sdp = hd[0];
            if (su && !sup) begin stu = 1'b1; anc_u = m_edge; end
            else if (!su || sd) begin stu = 1'b0; anc_u = m_edge; end
            else stu = repeat_due(m_edge - anc_u);
            if (sd && !sdp) begin std = 1'b1; anc_d = m_edge; end
            else if (!sd || su) begin std = 1'b0; anc_d = m_edge; end
            else std = repeat_due(m_edge - anc_d);

            if (stu && !std && m_lvl > 0) begin m_lvl--; changed = 1'b1; end
            else if (std && !stu && m_lvl < NL - 1) begin m_lvl++; changed = 1'b1; end

            if (changed) m_due = period(m_lvl);
            else if (bus.en) begin
                m_due--;
                if (m_due == 0) begin
                    r.tick = 1'b1;
                    m_due  = period(m_lvl);
                end
            end
        end
        r.edge_no = m_edge;
        r.level   = m_lvl;
        exp_q.push_back(r);
    end

    // Monitor: compare DUT outputs shortly after every rising edge.
    always begin
        exp_t r;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", -1, 0, 1);
        end else begin
            r = exp_q.pop_front();
            chk("tick",   r.edge_no, int'(bus.tick),   int'(r.tick));
            chk("level",  r.edge_no, int'(bus.level),  r.level);
            chk("at_min", r.edge_no, int'(bus.at_min), int'(r.level == 0));
            chk("at_max", r.edge_no, int'(bus.at_max), int'(r.level == NL - 1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
    endtask

    initial begin
        bus.up   = 1'b0;
        bus.down = 1'b0;
        bus.en   = 1'b0;
        cyc(3);
        bus.en = 1'b1;
        reset  = 1'b1;
        cyc(40);

        // Speed up to the floor, then try again at the floor.
        bus.up = 1'b1; cyc(3); bus.up = 1'b0; cyc(20);
        bus.up = 1'b1; cyc(3); bus.up = 1'b0; cyc(20);

        // Hold slow-down through first step, repeat and saturation.
        do_reset();
        bus.down = 1'b1; cyc(40); bus.down = 1'b0; cyc(10);

        // Simultaneous presses cancel.
        do_reset();
        cyc(5);
        bus.up = 1'b1; bus.down = 1'b1; cyc(4);
        bus.up = 1'b0; bus.down = 1'b0; cyc(20);

        // Enable gaps, including a step taken while disabled.
        cyc(3);
        bus.en = 1'b0; cyc(5); bus.en = 1'b1; cyc(20);
        bus.en = 1'b0;
        bus.down = 1'b1; cyc(3); bus.down = 1'b0; cyc(6);
        bus.en = 1'b1; cyc(40);

        // Mid-operation reset takes effect immediately.
        reset = 1'b0;
        #1;
        chk("async_reset_level", -1, int'(bus.level), DL);
        chk("async_reset_tick",  -1, int'(bus.tick), 0);
        cyc(2);
        reset = 1'b1;

        // Reset one cycle before the tick expected at edge 16.
        cyc(15);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(20);

        // Randomized button and enable activity.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 19) == 0) bus.up   = ~bus.up;
            if ($urandom_range(0, 19) == 0) bus.down = ~bus.down;
            if ($urandom_range(0, 29) == 0) bus.en   = ~bus.en;
            cyc(1);
        end
        bus.up = 1'b0; bus.down = 1'b0; bus.en = 1'b1;
        cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
